// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces raw key/switch pins against a shared
// 1 ms tick. Each key gets a clean active-high level and one-cycle press and
// release pulses. The 1 ms tick is exported for reuse by other blocks.
// Optional feature: define KEY_REPEAT_EN to add per-key auto-repeat press pulses
// while a key is held.
module key_debounce #(
  parameter int unsigned CLK_IN_MHZ      = 125,
  parameter logic        KEY_POLARITY    = 1'b0,
  parameter int unsigned NUM_KEYS        = 8,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] level_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic                tick_o
);

  localparam int unsigned TICK_DIV = CLK_IN_MHZ * 1000;
  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam int unsigned CW       = $clog2(DEBOUNCE_MS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_MS - 1);

  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("key_debounce: NUM_KEYS must be in 1..16");
  end
  if (DEBOUNCE_MS < 2 || DEBOUNCE_MS > 255) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_MS must be in 2..255");
  end
  if (REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_bad_repeat
    $error("key_debounce: repeat intervals must be at least 1 ms");
  end

  logic [PW-1:0]       presc_q;
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] sample;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] accept;
  logic [NUM_KEYS-1:0] rpt_pulse;
  logic [CW-1:0]       cnt_q [NUM_KEYS];

  // Free-running prescaler that wraps once per millisecond
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign tick_o = (presc_q == PRESC_LAST);

  // Two-flop synchroniser, reset to the idle pin level so reset exit looks released
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= {NUM_KEYS{~KEY_POLARITY}};
      sync2_q <= {NUM_KEYS{~KEY_POLARITY}};
    end else begin
      sync1_q <= keys_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise so that 1 always means pressed
  assign sample = ~(sync2_q ^ {NUM_KEYS{KEY_POLARITY}});

  // A key is accepted on the tick that completes DEBOUNCE_MS ticks of a steady new level
  always_comb begin
    accept = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      accept[k] = tick_o && (sample[k] != level_q[k]) && (cnt_q[k] == CNT_LAST);
    end
  end

  // Per-key debounce counters and accepted level; any return to the old level restarts the count
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      level_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (sample[k] == level_q[k]) begin
          cnt_q[k] <= '0;
        end else if (accept[k]) begin
          cnt_q[k]   <= '0;
          level_q[k] <= sample[k];
        end else if (tick_o) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Registered one-cycle press/release pulses, aligned with the level update
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= (accept & sample) | rpt_pulse;
      release_q <= accept & ~sample;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                       : REPEAT_RATE_MS;
  localparam int unsigned RW      = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_MS - 1);

  logic [RW-1:0]       rpt_cnt_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] rpt_armed_q;

  // Repeat fires when the held-key timer reaches the initial delay, then the repeat rate
  always_comb begin
    rpt_pulse = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      rpt_pulse[k] = level_q[k] && !accept[k] && tick_o &&
                     (rpt_cnt_q[k] == (rpt_armed_q[k] ? RATE_LAST : DELAY_LAST));
    end
  end

  // Held-key timers; cleared while released and on the accepting edge itself
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rpt_armed_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        rpt_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (!level_q[k] || accept[k]) begin
          rpt_cnt_q[k]   <= '0;
          rpt_armed_q[k] <= 1'b0;
        end else if (rpt_pulse[k]) begin
          rpt_cnt_q[k]   <= '0;
          rpt_armed_q[k] <= 1'b1;
        end else if (tick_o) begin
          rpt_cnt_q[k] <= rpt_cnt_q[k] + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_pulse = '0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the board LED display drivers. Samples up to NUM_KEYS raw push-button/DIP-switch pins.
- Synchronises each pin, debounces it against a shared 1 ms tick, and presents a clean active-high level per key plus single-cycle press/release pulses.
- Feeds the board-check sequencer and any mode-select logic on the same clock domain.

Parameters:
- CLK_IN_MHZ, 125: input clock frequency in MHz; the 1 ms tick divisor is CLK_IN_MHZ*1000.
- KEY_POLARITY, 1'b0: raw pin level meaning "pressed" (0 = active-low buttons).
- NUM_KEYS, 8: number of independent key inputs, range 1..16.
- DEBOUNCE_MS, 10: number of consecutive 1 ms ticks a new level must persist before it is accepted, range 2..255.
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat pulse. Used only with KEY_REPEAT_EN.
- REPEAT_RATE_MS, 100: interval between auto-repeat pulses. Used only with KEY_REPEAT_EN.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  reset, asynchronous assert, active-low.
- keys_i  input  NUM_KEYS  raw asynchronous key pins.
- level_o  output  NUM_KEYS  debounced key state, 1 = pressed, regardless of KEY_POLARITY.
- press_o  output  NUM_KEYS  one-cycle pulse when a key is accepted as pressed.
- release_o  output  NUM_KEYS  one-cycle pulse when a key is accepted as released.
- tick_o  output  1  one-cycle 1 ms tick, exported for reuse by other blocks.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low; all flops reset on its falling edge.
- Reset values:
  - level_o, press_o, release_o, tick_o = 0.
  - Prescaler and all per-key counters = 0.
  - Synchroniser flops = ~KEY_POLARITY (the inactive raw level), so there is no spurious press at reset exit.
- Synchroniser:
  - Two flops per key.
  - Normalised sample s[k] = sync2[k] XNOR KEY_POLARITY, so 1 = pressed.
- Prescaler:
  - Counts 0..CLK_IN_MHZ*1000-1 and wraps to 0.
  - tick_o is asserted combinationally-registered for the single cycle in which the count equals its terminal value.
  - Counter width is $clog2(CLK_IN_MHZ*1000).
- Per-key debounce counter cnt[k], width $clog2(DEBOUNCE_MS). Evaluated every cycle:
  - If s[k] == level_o[k]: cnt[k] <= 0 immediately, with no tick required. Any bounce back restarts the count.
  - Else, on a tick with cnt[k] == DEBOUNCE_MS-1: level_o[k] <= s[k], cnt[k] <= 0. press_o[k] is asserted if s[k] = 1, release_o[k] if s[k] = 0, on the same edge that level_o updates.
  - Else, on a tick: cnt[k] <= cnt[k]+1.
  - Else (no tick): hold.
- Latency:
  - Pin change to level_o change is 2 cycles (sync) plus between (DEBOUNCE_MS-1) and DEBOUNCE_MS ms, plus 1 cycle.
  - The bound depends on tick phase.
- Pulse outputs:
  - press_o and release_o are high for exactly one cycle.
  - They are never both high for the same key.
- Independence:
  - Keys are fully independent.
  - Any number of keys may change on the same cycle, each producing its own pulse.
- Key held through reset: after rstn_i deasserts, the held key is accepted as a press after the normal debounce time.
- Reset mid-debounce: the count is discarded. No pulse is generated, either during reset or on the reset edge.
- Continuous bouncing faster than 1 ms: level_o never changes.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each key has a repeat counter, clocked on tick_o, that runs while level_o[k] = 1.
  - Counter width is $clog2(max(REPEAT_DELAY_MS, REPEAT_RATE_MS)).
  - First extra press_o[k] pulse: REPEAT_DELAY_MS ticks after the accepted press.
  - Further pulses: every REPEAT_RATE_MS ticks after that.
  - The counter clears when level_o[k] falls and on reset.
  - release_o behaviour is unchanged.
- Not defined:
  - No repeat logic is instantiated.
  - press_o pulses only once per accepted press.

Test Plan (CLK_IN_MHZ=1, so tick every 1000 cycles; DEBOUNCE_MS=4; KEY_POLARITY=0; NUM_KEYS=8):
- Reset with keys_i=8'hFF, then idle 20000 cycles: level_o=0, no press_o or release_o pulse, tick_o pulses every 1000 cycles.
- Drive keys_i[0]=0 and hold: level_o[0] rises between 3000+3 and 4000+3 cycles after the drive; press_o[0] is high for exactly 1 cycle on that edge. Then set keys_i[0]=1: release_o[0] pulses one time, level_o[0] returns to 0.
- Toggle keys_i[3] every 700 cycles for 20 ms: level_o[3]=0 throughout, zero pulses.
- Drive keys_i[7:6]=2'b00 on the same cycle: level_o[7:6] and press_o[7:6] assert together on the same edge.
- Hold keys_i[2]=0 during reset, then deassert rstn_i: no pulse during reset; press_o[2] follows within 4 ms. Separately, assert rstn_i at cnt=2: all outputs go to 0 at once, and no pulse on reset exit until 4 fresh ticks have elapsed.
- With KEY_REPEAT_EN, REPEAT_DELAY_MS=6, REPEAT_RATE_MS=2, hold key 1 pressed for 15 ms: press_o[1] pulses at acceptance, then +6, +8, +10 ms, and so on. Release: repeats stop and one release_o[1] pulse is generated.
